// File: rtl/traffic_pkg.sv
// Shared definitions for the road-light timing stage and its controllers:
// timer state encoding, default BCD intervals, BCD byte type and light colours.
package traffic_pkg;

    typedef logic [7:0] bcd8_t;

    typedef enum logic [1:0] {
        RUN_SHORT = 2'd0,
        RUN_LONG  = 2'd1,
        EXPIRED   = 2'd2
    } timer_state_e;

    typedef enum logic [1:0] {
        LIGHT_RED    = 2'd0,
        LIGHT_YELLOW = 2'd1,
        LIGHT_GREEN  = 2'd2
    } light_color_e;

    localparam bcd8_t T_GREEN  = 8'h30;
    localparam bcd8_t T_YELLOW = 8'h05;

endpackage

// File: rtl/bcd_plus.sv
// Combinational 2-digit BCD incrementer {tens, ones}; saturates at 99.
module bcd_plus
    import traffic_pkg::*;
(
    input  bcd8_t bcd_i,
    output bcd8_t bcd_o
);

    logic [3:0] tens;
    logic [3:0] ones;

    assign tens = bcd_i[7:4];
    assign ones = bcd_i[3:0];

    always_comb begin
        bcd_o = bcd_i;
        if (bcd_i == 8'h99) begin
            bcd_o = 8'h99;
        end else if (ones >= 4'd9) begin
            bcd_o = {tens + 4'd1, 4'd0};
        end else begin
            bcd_o = {tens, ones + 4'd1};
        end
    end

endmodule

// File: rtl/traffic_interval_timer.sv
// Start-pulse interval timer: prescaled seconds counted in BCD, short/long flags.
// Optional `hold` input when TRAFFIC_TIMER_HOLD_EN is defined.
module traffic_interval_timer
    import traffic_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 8,
    parameter bcd8_t       T_SHORT       = T_YELLOW,
    parameter bcd8_t       T_LONG        = T_GREEN
) (
    input  logic       clk,
    input  logic       rst,
`ifdef TRAFFIC_TIMER_HOLD_EN
    input  logic       hold,
`endif
    input  logic       start,
    output logic       timeout,
    output logic       Timeout,
    output logic       sec_tick,
    output logic [7:0] elapsed_bcd
);

    localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_SEC - 1);

    timer_state_e  state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    bcd8_t         elapsed_q, elapsed_d;
    bcd8_t         elapsed_inc;
    logic          timeout_q, timeout_d;
    logic          Timeout_q, Timeout_d;
    logic          tick_q, tick_d;
    logic          hold_w;
    logic          advance;
    logic          terminal;

`ifdef TRAFFIC_TIMER_HOLD_EN
    assign hold_w = hold;
`else
    assign hold_w = 1'b0;
`endif

    bcd_plus u_bcd_plus (
        .bcd_i (elapsed_q),
        .bcd_o (elapsed_inc)
    );

    assign advance  = (state_q != EXPIRED) && !hold_w;
    assign terminal = advance && (pre_q == PRE_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN_SHORT;
            pre_q     <= '0;
            elapsed_q <= '0;
            timeout_q <= 1'b0;
            Timeout_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            elapsed_q <= elapsed_d;
            timeout_q <= timeout_d;
            Timeout_q <= Timeout_d;
            tick_q    <= tick_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = RUN_SHORT;
        end else if (terminal) begin
            if (state_q == RUN_SHORT && elapsed_inc == T_SHORT) begin
                state_d = RUN_LONG;
            end else if (state_q == RUN_LONG && elapsed_inc == T_LONG) begin
                state_d = EXPIRED;
            end
        end
    end

    // Flags are set on the same edge that the matching second is counted.
    always_comb begin
        pre_d     = pre_q;
        elapsed_d = elapsed_q;
        timeout_d = timeout_q;
        Timeout_d = Timeout_q;
        tick_d    = 1'b0;
        if (start) begin
            pre_d     = '0;
            elapsed_d = '0;
            timeout_d = 1'b0;
            Timeout_d = 1'b0;
        end else if (terminal) begin
            pre_d     = '0;
            tick_d    = 1'b1;
            elapsed_d = elapsed_inc;
            if (state_q == RUN_SHORT && elapsed_inc == T_SHORT) begin
                timeout_d = 1'b1;
            end
            if (state_q == RUN_LONG && elapsed_inc == T_LONG) begin
                Timeout_d = 1'b1;
            end
        end else if (advance) begin
            pre_d = pre_q + PW'(1);
        end
    end

    assign timeout     = timeout_q;
    assign Timeout     = Timeout_q;
    assign sec_tick    = tick_q;
    assign elapsed_bcd = elapsed_q;

endmodule

// File: tb/tb_traffic_interval_timer.sv
// Scoreboard bench for traffic_interval_timer (TICKS_PER_SEC=4, 5 s / 30 s intervals).
// Hold stimulus is exercised only when TRAFFIC_TIMER_HOLD_EN is defined.
module tb_traffic_interval_timer;

    localparam int unsigned TPS       = 4;
    localparam int unsigned SHORT_SEC = 5;
    localparam int unsigned LONG_SEC  = 30;

    typedef struct packed {
        logic       tick;
        logic       to_s;
        logic       to_l;
        logic [7:0] el;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       timeout;
    logic       Timeout;
    logic       sec_tick;
    logic [7:0] elapsed_bcd;
`ifdef TRAFFIC_TIMER_HOLD_EN
    logic       hold;
`endif

    int checks   = 0;
    int failures = 0;
    exp_t exp_q[$];
    int unsigned n_run = 0;   // counted clock cycles since last restart

    traffic_interval_timer #(
        .TICKS_PER_SEC (TPS),
        .T_SHORT       (8'h05),
        .T_LONG        (8'h30)
    ) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef TRAFFIC_TIMER_HOLD_EN
        .hold        (hold),
`endif
        .start       (start),
        .timeout     (timeout),
        .Timeout     (Timeout),
        .sec_tick    (sec_tick),
        .elapsed_bcd (elapsed_bcd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int unsigned v);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic step(input bit r, input bit s, input bit h);
        exp_t e;
        int unsigned secs;
        @(negedge clk);
        rst   = r;
        start = s;
`ifdef TRAFFIC_TIMER_HOLD_EN
        hold  = h;
`endif
        e.tick = 1'b0;
        if (r || s) begin
            n_run = 0;
        end else if (!h && n_run < LONG_SEC * TPS) begin
            n_run++;
            e.tick = (n_run % TPS) == 0;
        end
        secs   = n_run / TPS;
        e.to_s = secs >= SHORT_SEC;
        e.to_l = secs >= LONG_SEC;
        e.el   = to_bcd(secs);
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("elapsed_bcd", elapsed_bcd, e.el);
                chk("sec_tick", {7'd0, sec_tick}, {7'd0, e.tick});
                chk("timeout", {7'd0, timeout}, {7'd0, e.to_s});
                chk("Timeout", {7'd0, Timeout}, {7'd0, e.to_l});
            end
        end
    end

    initial begin : driver
        bit r;
        bit h;
        rst   = 1'b1;
        start = 1'b0;
`ifdef TRAFFIC_TIMER_HOLD_EN
        hold  = 1'b0;
`endif
        repeat (3) step(1, 0, 0);
        repeat (130) step(0, 0, 0);
        repeat (50) step(0, 0, 0);
        step(0, 1, 0);
        repeat (45) step(0, 0, 0);

        // Restart exactly on a prescaler terminal count.
        for (int i = 0; i < 2 * TPS && (n_run % TPS) != TPS - 1; i++) step(0, 0, 0);
        step(0, 1, 0);
        repeat (130) step(0, 0, 0);
        repeat (40) step(0, 0, 0);

        // Reset mid RUN_LONG at elapsed 17.
        step(0, 1, 0);
        for (int i = 0; i < 200 && n_run < 17 * TPS + 1; i++) step(0, 0, 0);
        step(1, 0, 0);
        repeat (30) step(0, 0, 0);

        // Multi-cycle start and back-to-back pulses.
        repeat (5) step(0, 1, 0);
        step(0, 0, 0);
        step(0, 1, 0);
        repeat (10) step(0, 0, 0);

`ifdef TRAFFIC_TIMER_HOLD_EN
        step(0, 1, 0);
        for (int i = 0; i < 40 && n_run < 3 * TPS; i++) step(0, 0, 0);
        repeat (10) step(0, 0, 1);
        repeat (25) step(0, 0, 0);
        repeat (3) step(0, 0, 1);
        step(0, 1, 1);
        repeat (5) step(0, 0, 1);
        repeat (5) step(0, 0, 0);
`endif

        for (int seg = 0; seg < 40; seg++) begin
            for (int c = 0; c < int'($urandom_range(0, 140)); c++) begin
                h = 1'b0;
`ifdef TRAFFIC_TIMER_HOLD_EN
                h = ($urandom_range(0, 7) == 0);
`endif
                step(0, 0, h);
            end
            r = ($urandom_range(0, 7) == 0);
            for (int c = 0; c < int'($urandom_range(1, 3)); c++) step(r, !r, 0);
        end

        repeat (3) step(0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
